// File: rtl/queue_pkg.sv
// Shared types and pointer helpers for the queue read-side deque.
// Pointers wrap at DEPTH-1 so DEPTH does not have to be a power of two.
package queue_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } deq_state_e;

  function automatic int ptr_inc(input int ptr, input int depth);
    if (ptr >= depth - 1) begin
      return 0;
    end else begin
      return ptr + 1;
    end
  endfunction

  function automatic int ptr_dec(input int ptr, input int depth);
    if (ptr == 0) begin
      return depth - 1;
    end else begin
      return ptr - 1;
    end
  endfunction

endpackage

// File: rtl/queue_store.sv
// DEPTH x WIDTH register array: one write port, two combinational read ports.
// Storage is intentionally not reset.
module queue_store #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read ports; addresses beyond DEPTH return zero instead of X.
  always_comb begin
    if (int'(raddr_a) < DEPTH) begin
      rdata_a = mem_q[raddr_a];
    end else begin
      rdata_a = {WIDTH{1'b0}};
    end
    if (int'(raddr_b) < DEPTH) begin
      rdata_b = mem_q[raddr_b];
    end else begin
      rdata_b = {WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/queue_pop_reader.sv
// Circular-buffer deque read side: pop_front, pop_back, peek and burst drain,
// with push_back from a writer and a live element count.
module queue_pop_reader
  import queue_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int WIDTH = 32,
  parameter int PW    = $clog2(DEPTH),
  parameter int SW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ready,
  input  logic             pop_req,
  input  logic             pop_from_back,
  input  logic             drain_start,
  output logic             drain_busy,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_last,
  output logic             pop_err,
  output logic [SW-1:0]    size,
  output logic             empty,
  output logic             full,
  input  logic [PW-1:0]    peek_idx,
  output logic [WIDTH-1:0] peek_data,
  output logic             peek_hit
);

  deq_state_e       state_q, state_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [SW-1:0]    size_q, size_d;
  logic             pop_valid_q, pop_valid_d;
  logic [WIDTH-1:0] pop_data_q, pop_data_d;
  logic             pop_last_q, pop_last_d;
  logic             pop_err_q, pop_err_d;
  logic             drain_busy_q, drain_busy_d;

  logic             empty_s, full_s, push_ready_s, push_acc_s;
  logic             pop_fr_s, pop_bk_s, pop_any_s, err_s, start_drain_s, end_drain_s;
  logic [PW-1:0]    head_inc_s, tail_inc_s, tail_dec_s;
  logic [PW-1:0]    rd_addr_s, wr_addr_s, peek_addr_s;
  logic [WIDTH-1:0] rd_data_s;
  int               peek_sum_s;

  assign empty_s      = (size_q == SW'(0));
  assign full_s       = (size_q == SW'(DEPTH));
  assign push_ready_s = !full_s && (state_q == IDLE);
  assign push_acc_s   = push_valid && push_ready_s;

  assign head_inc_s = PW'(ptr_inc(int'(head_q), DEPTH));
  assign tail_inc_s = PW'(ptr_inc(int'(tail_q), DEPTH));
  assign tail_dec_s = PW'(ptr_dec(int'(tail_q), DEPTH));

  // Decode which operation this cycle performs.
  always_comb begin
    pop_fr_s      = 1'b0;
    pop_bk_s      = 1'b0;
    err_s         = 1'b0;
    start_drain_s = 1'b0;
    end_drain_s   = 1'b0;
    case (state_q)
      IDLE: begin
        // drain_start wins over a coincident pop_req, which is dropped
        if (drain_start && !empty_s) begin
          start_drain_s = 1'b1;
        end else if (pop_req) begin
          if (empty_s) begin
            err_s = 1'b1;
          end else if (pop_from_back) begin
            pop_bk_s = 1'b1;
          end else begin
            pop_fr_s = 1'b1;
          end
        end else begin
          pop_fr_s = 1'b0;
        end
      end
      DRAIN: begin
        pop_fr_s    = !empty_s;
        end_drain_s = (size_q <= SW'(1));
      end
      default: begin
        end_drain_s = 1'b1;
      end
    endcase
  end

  assign pop_any_s = pop_fr_s || pop_bk_s;
  // A push coinciding with pop_back reuses the slot just vacated at tail-1.
  assign rd_addr_s = pop_bk_s ? tail_dec_s : head_q;
  assign wr_addr_s = pop_bk_s ? tail_dec_s : tail_q;

  // Next-state for pointers, count, FSM and registered pop outputs.
  always_comb begin
    head_d = pop_fr_s ? head_inc_s : head_q;
    if (push_acc_s && !pop_bk_s) begin
      tail_d = tail_inc_s;
    end else if (!push_acc_s && pop_bk_s) begin
      tail_d = tail_dec_s;
    end else begin
      tail_d = tail_q;
    end
    if (push_acc_s && !pop_any_s) begin
      size_d = size_q + SW'(1);
    end else if (!push_acc_s && pop_any_s) begin
      size_d = size_q - SW'(1);
    end else begin
      size_d = size_q;
    end
    if (start_drain_s) begin
      state_d = DRAIN;
    end else if (end_drain_s) begin
      state_d = IDLE;
    end else begin
      state_d = state_q;
    end
    pop_valid_d  = pop_any_s;
    pop_data_d   = pop_any_s ? rd_data_s : pop_data_q;
    pop_last_d   = end_drain_s && pop_fr_s;
    pop_err_d    = err_s;
    drain_busy_d = (state_d == DRAIN);
  end

  // Peek address: head + index, folded once into 0..DEPTH-1.
  always_comb begin
    peek_sum_s = int'(head_q) + int'(peek_idx);
    if (peek_sum_s >= DEPTH) begin
      peek_addr_s = PW'(peek_sum_s - DEPTH);
    end else begin
      peek_addr_s = PW'(peek_sum_s);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      head_q       <= {PW{1'b0}};
      tail_q       <= {PW{1'b0}};
      size_q       <= {SW{1'b0}};
      pop_valid_q  <= 1'b0;
      pop_data_q   <= {WIDTH{1'b0}};
      pop_last_q   <= 1'b0;
      pop_err_q    <= 1'b0;
      drain_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      size_q       <= size_d;
      pop_valid_q  <= pop_valid_d;
      pop_data_q   <= pop_data_d;
      pop_last_q   <= pop_last_d;
      pop_err_q    <= pop_err_d;
      drain_busy_q <= drain_busy_d;
    end
  end

  queue_store #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (PW)
  ) u_store (
    .clk     (clk),
    .we      (push_acc_s),
    .waddr   (wr_addr_s),
    .wdata   (push_data),
    .raddr_a (rd_addr_s),
    .rdata_a (rd_data_s),
    .raddr_b (peek_addr_s),
    .rdata_b (peek_data)
  );

  assign push_ready = push_ready_s;
  assign drain_busy = drain_busy_q;
  assign pop_valid  = pop_valid_q;
  assign pop_data   = pop_data_q;
  assign pop_last   = pop_last_q;
  assign pop_err    = pop_err_q;
  assign size       = size_q;
  assign empty      = empty_s;
  assign full       = full_s;
  assign peek_hit   = (SW'(peek_idx) < size_q);

endmodule

// File: tb/tb_queue_pop_reader.sv
// Directed bench for queue_pop_reader with hand-computed expectations.
module tb_queue_pop_reader;

  localparam int DEPTH = 5;
  localparam int WIDTH = 32;
  localparam int PW    = $clog2(DEPTH);
  localparam int SW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             push_valid = 1'b0;
  logic [WIDTH-1:0] push_data = '0;
  logic             push_ready;
  logic             pop_req = 1'b0;
  logic             pop_from_back = 1'b0;
  logic             drain_start = 1'b0;
  logic             drain_busy;
  logic             pop_valid;
  logic [WIDTH-1:0] pop_data;
  logic             pop_last;
  logic             pop_err;
  logic [SW-1:0]    size;
  logic             empty;
  logic             full;
  logic [PW-1:0]    peek_idx = '0;
  logic [WIDTH-1:0] peek_data;
  logic             peek_hit;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  queue_pop_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_req(pop_req), .pop_from_back(pop_from_back),
    .drain_start(drain_start), .drain_busy(drain_busy),
    .pop_valid(pop_valid), .pop_data(pop_data), .pop_last(pop_last),
    .pop_err(pop_err), .size(size), .empty(empty), .full(full),
    .peek_idx(peek_idx), .peek_data(peek_data), .peek_hit(peek_hit)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    push_valid = 1'b1;
    push_data  = v;
    tick();
    push_valid = 1'b0;
  endtask

  task automatic pop(input logic back);
    pop_req       = 1'b1;
    pop_from_back = back;
    tick();
    pop_req       = 1'b0;
    pop_from_back = 1'b0;
  endtask

  task automatic peek(input int idx, input logic [31:0] exp_data, input logic exp_hit);
    peek_idx = PW'(idx);
    #1;
    check("peek_hit", 32'(peek_hit), 32'(exp_hit));
    if (exp_hit) begin
      check("peek_data", peek_data, exp_data);
    end
  endtask

  logic [31:0] drain_exp [5];

  initial begin
    drain_exp[0] = 32'd40;  drain_exp[1] = 32'd50;  drain_exp[2] = 32'd100;
    drain_exp[3] = 32'd200; drain_exp[4] = 32'd300;

    // Reset state
    #12;
    check("rst_size", 32'(size), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_push_ready", 32'(push_ready), 32'd1);
    check("rst_pop_valid", 32'(pop_valid), 32'd0);
    check("rst_pop_data", pop_data, 32'd0);
    check("rst_drain_busy", 32'(drain_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // 1: push 5,15,25 and peek
    push(32'd5); push(32'd15); push(32'd25);
    check("t1_size", 32'(size), 32'd3);
    check("t1_empty", 32'(empty), 32'd0);
    peek(1, 32'd15, 1'b1);
    peek(3, 32'd0, 1'b0);

    // 2: pop_front then pop_back
    pop(1'b0);
    check("t2_front_valid", 32'(pop_valid), 32'd1);
    check("t2_front_data", pop_data, 32'd5);
    check("t2_front_size", 32'(size), 32'd2);
    pop(1'b1);
    check("t2_back_valid", 32'(pop_valid), 32'd1);
    check("t2_back_data", pop_data, 32'd25);
    check("t2_back_size", 32'(size), 32'd1);
    tick();
    check("t2_valid_pulse", 32'(pop_valid), 32'd0);
    pop(1'b0);
    check("t2_last_data", pop_data, 32'd15);
    check("t2_empty", 32'(empty), 32'd1);

    // 3: empty pop error, drain on empty ignored, error with coincident push
    pop(1'b0);
    check("t3_err", 32'(pop_err), 32'd1);
    check("t3_err_novalid", 32'(pop_valid), 32'd0);
    check("t3_err_size", 32'(size), 32'd0);
    tick();
    check("t3_err_pulse", 32'(pop_err), 32'd0);
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    check("t3_drain_empty_busy", 32'(drain_busy), 32'd0);
    check("t3_drain_empty_err", 32'(pop_err), 32'd0);
    push_valid = 1'b1; push_data = 32'd33; pop_req = 1'b1;
    tick();
    push_valid = 1'b0; pop_req = 1'b0;
    check("t3_errpush_err", 32'(pop_err), 32'd1);
    check("t3_errpush_valid", 32'(pop_valid), 32'd0);
    check("t3_errpush_size", 32'(size), 32'd1);
    pop(1'b0);
    check("t3_errpush_data", pop_data, 32'd33);

    // 3: fill to full, overflow push ignored
    push(32'd10); push(32'd20); push(32'd30); push(32'd40); push(32'd50);
    check("t3_full", 32'(full), 32'd1);
    check("t3_full_ready", 32'(push_ready), 32'd0);
    push(32'd60);
    check("t3_overflow_size", 32'(size), 32'd5);
    peek(0, 32'd10, 1'b1);
    peek(4, 32'd50, 1'b1);

    // 4: wrap and drain
    pop(1'b0); check("t4_pop0", pop_data, 32'd10);
    pop(1'b0); check("t4_pop1", pop_data, 32'd20);
    pop(1'b0); check("t4_pop2", pop_data, 32'd30);
    push(32'd100); push(32'd200); push(32'd300);
    check("t4_full", 32'(full), 32'd1);
    drain_start = 1'b1;
    pop_req     = 1'b1;
    tick();
    drain_start = 1'b0;
    pop_req     = 1'b0;
    check("t4_busy", 32'(drain_busy), 32'd1);
    check("t4_pop_dropped", 32'(pop_valid), 32'd0);
    push_valid = 1'b1;
    push_data  = 32'd999;
    for (int i = 0; i < 5; i++) begin
      check("t4_ready_blocked", 32'(push_ready), 32'd0);
      tick();
      check("t4_drain_valid", 32'(pop_valid), 32'd1);
      check("t4_drain_data", pop_data, drain_exp[i]);
      check("t4_drain_last", 32'(pop_last), (i == 4) ? 32'd1 : 32'd0);
      check("t4_drain_busy", 32'(drain_busy), (i == 4) ? 32'd0 : 32'd1);
    end
    push_valid = 1'b0;
    check("t4_size_after", 32'(size), 32'd0);
    tick();
    check("t4_valid_after", 32'(pop_valid), 32'd0);
    check("t4_last_after", 32'(pop_last), 32'd0);

    // 5: simultaneous push and pop_back at size 2
    push(32'd7); push(32'd8);
    push_valid = 1'b1; push_data = 32'd9;
    pop_req = 1'b1; pop_from_back = 1'b1;
    tick();
    push_valid = 1'b0; pop_req = 1'b0; pop_from_back = 1'b0;
    check("t5_data", pop_data, 32'd8);
    check("t5_size", 32'(size), 32'd2);
    peek(0, 32'd7, 1'b1);
    peek(1, 32'd9, 1'b1);

    // 6: async reset mid-drain
    push(32'd1); push(32'd2);
    check("t6_size", 32'(size), 32'd4);
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    tick();
    check("t6_first", pop_data, 32'd7);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(pop_valid), 32'd0);
    check("t6_rst_busy", 32'(drain_busy), 32'd0);
    check("t6_rst_size", 32'(size), 32'd0);
    check("t6_rst_empty", 32'(empty), 32'd1);
    check("t6_rst_data", pop_data, 32'd0);
    check("t6_rst_last", 32'(pop_last), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_no_valid", 32'(pop_valid), 32'd0);
    end
    check("t6_ready", 32'(push_ready), 32'd1);
    push(32'd77);
    check("t6_push_size", 32'(size), 32'd1);
    peek(0, 32'd77, 1'b1);
    pop(1'b0);
    check("t6_pop_data", pop_data, 32'd77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
